sfft_stream_decoder: RTL and testbench

SFFT_STREAM_DECODER -- requirements
Module: sfft_stream_decoder

---
 rtl/sfft_stream_decoder_if.sv | 31 +++
 rtl/sfft_stream_decoder.sv | 118 +++++++++++
 tb/tb_sfft_stream_decoder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sfft_stream_decoder_if.sv
// Bus bundle for the stochastic-FFT bitstream decoder: sample inputs, result beats, debug state.
// Result beats use valid/ready: a beat transfers on a rising edge where oValid && iReady; while oValid=1 and iReady=0 the beat (oIdx/oRealVal/oImgVal) holds.
interface sfft_stream_decoder_if #(
   parameter int BITWIDTH  = 8,
   parameter int NUMINPUTS = 8,
   parameter int IDXW      = $clog2(NUMINPUTS)
);
   logic                        iEn;
   logic                        iClr;
   logic                        iStart;
   logic [NUMINPUTS-1:0]        iReal;
   logic [NUMINPUTS-1:0]        iImg;
   logic                        iReady;
   logic                        oBusy;
   logic                        oValid;
   logic [IDXW-1:0]             oIdx;
   logic signed [BITWIDTH+1:0]  oRealVal;
   logic signed [BITWIDTH+1:0]  oImgVal;
   logic                        oDone;
   logic [1:0]                  oState;

   modport slave (
      input  iEn, iClr, iStart, iReal, iImg, iReady,
      output oBusy, oValid, oIdx, oRealVal, oImgVal, oDone, oState
   );

   modport master (
      output iEn, iClr, iStart, iReal, iImg, iReady,
      input  oBusy, oValid, oIdx, oRealVal, oImgVal, oDone, oState
   );
endinterface

// File: rtl/sfft_stream_decoder.sv
// Counts ones on each bipolar bitstream lane over a 2^BITWIDTH-sample window,
// then streams the decoded signed values (2*count - 2^BITWIDTH) one lane per beat.
module sfft_stream_decoder #(
   parameter int BITWIDTH  = 8,
   parameter int NUMINPUTS = 8,
   parameter int IDXW      = $clog2(NUMINPUTS)
) (
   input  logic                iClk,
   input  logic                iRstN,
   sfft_stream_decoder_if.slave bus
);
   localparam int CW = BITWIDTH + 1;
   localparam int VW = BITWIDTH + 2;
   localparam logic [VW-1:0] WIN = VW'(1 << BITWIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [BITWIDTH-1:0] r_win;
   logic [CW-1:0]   r_cnt_re [NUMINPUTS];
   logic [CW-1:0]   r_cnt_im [NUMINPUTS];
   logic [CW-1:0]   r_buf_re [NUMINPUTS];
   logic [CW-1:0]   r_buf_im [NUMINPUTS];
   logic [CW-1:0]   w_sum_re [NUMINPUTS];
   logic [CW-1:0]   w_sum_im [NUMINPUTS];
   logic [IDXW-1:0] r_idx;
   logic            r_done;
   logic            w_sample;
   logic            w_close;
   logic            w_accept;
   logic            w_last;

   // Full-width decode; {c,0} is exactly VW bits so the wrap gives the signed result.
   function automatic logic [VW-1:0] decode(input logic [CW-1:0] c);
      return {c, 1'b0} - WIN;
   endfunction

   assign w_sample = (r_state == ACCUM) && bus.iEn;
   assign w_close  = w_sample && (r_win == '1);
   assign w_accept = (r_state == DRAIN) && bus.iReady;
   assign w_last   = w_accept && (r_idx == IDXW'(NUMINPUTS - 1));

   always_ff @(posedge iClk) begin
      if (!iRstN) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (bus.iClr) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (bus.iStart) w_next = ACCUM;
            ACCUM:   if (w_close)    w_next = DRAIN;
            DRAIN:   if (w_last)     w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   always_comb begin
      for (int k = 0; k < NUMINPUTS; k++) begin
         w_sum_re[k] = r_cnt_re[k] + CW'(bus.iReal[k]);
         w_sum_im[k] = r_cnt_im[k] + CW'(bus.iImg[k]);
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRstN || bus.iClr) begin
         r_win  <= '0;
         r_idx  <= '0;
         r_done <= 1'b0;
         for (int k = 0; k < NUMINPUTS; k++) begin
            r_cnt_re[k] <= '0;
            r_cnt_im[k] <= '0;
            r_buf_re[k] <= '0;
            r_buf_im[k] <= '0;
         end
      end else begin
         r_done <= w_last;
         if ((r_state == IDLE) && bus.iStart) begin
            r_win <= '0;
            r_idx <= '0;
            for (int k = 0; k < NUMINPUTS; k++) begin
               r_cnt_re[k] <= '0;
               r_cnt_im[k] <= '0;
            end
         end else if (w_sample) begin
            r_win <= r_win + 1'b1;
            for (int k = 0; k < NUMINPUTS; k++) begin
               r_cnt_re[k] <= w_sum_re[k];
               r_cnt_im[k] <= w_sum_im[k];
               // The closing sample is folded into the snapshot directly.
               if (w_close) begin
                  r_buf_re[k] <= w_sum_re[k];
                  r_buf_im[k] <= w_sum_im[k];
               end
            end
         end
         // Index wraps back to 0 on the last accept, ready for the next window.
         if (w_accept) r_idx <= r_idx + 1'b1;
      end
   end

   assign bus.oBusy    = (r_state != IDLE);
   assign bus.oValid   = (r_state == DRAIN);
   assign bus.oIdx     = (r_state == DRAIN) ? r_idx : '0;
   assign bus.oRealVal = (r_state == DRAIN) ? decode(r_buf_re[r_idx]) : '0;
   assign bus.oImgVal  = (r_state == DRAIN) ? decode(r_buf_im[r_idx]) : '0;
   assign bus.oDone    = r_done;
   assign bus.oState   = r_state;
endmodule

// File: tb/tb_sfft_stream_decoder.sv
// Randomized bench for sfft_stream_decoder: per-lane one-counts from generated bitstreams
// give the expected beats, which are compared as they drain.
module tb_sfft_stream_decoder;
   localparam int BITWIDTH  = 8;
   localparam int NUMINPUTS = 8;
   localparam int IDXW      = 3;
   localparam int VW        = BITWIDTH + 2;
   localparam int WIN       = 1 << BITWIDTH;
   localparam int BW        = IDXW + 2 * VW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [BW-1:0] exp_q[$];

   sfft_stream_decoder_if #(.BITWIDTH(BITWIDTH), .NUMINPUTS(NUMINPUTS)) bus ();

   sfft_stream_decoder #(.BITWIDTH(BITWIDTH), .NUMINPUTS(NUMINPUTS)) dut (
      .iClk  (clk),
      .iRstN (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] decode_ref(input int cnt);
      return VW'(2 * cnt - WIN);
   endfunction

   // Bit of sample s for a lane; comp 0 = real, 1 = imaginary.
   function automatic bit gen_bit(input int pat, input int comp, input int lane, input int s);
      case (pat)
         0:       return (comp == 0);
         1:       return (comp == 0) ? (s % 2 == 0) : (lane == 3 && s < 192);
         3:       return 1'b1;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   function automatic logic [63:0] out_word();
      return 64'({bus.oBusy, bus.oValid, bus.oDone, bus.oIdx, bus.oRealVal, bus.oImgVal});
   endfunction

   // en_mode: 0 always, 1 odd clocks only, 2 random.
   task automatic run_accum(input int pat, input int en_mode, input bit start_noise);
      int cnt_re[NUMINPUTS];
      int cnt_im[NUMINPUTS];
      int s = 0;
      int c = 0;
      int early_valid = 0;
      for (int k = 0; k < NUMINPUTS; k++) begin
         cnt_re[k] = 0;
         cnt_im[k] = 0;
      end
      @(negedge clk);
      bus.iStart = 1'b1;
      bus.iEn    = 1'($urandom);
      @(negedge clk);
      bus.iStart = 1'b0;
      check_val("busy_accum", 64'(bus.oBusy), 64'(1));
      while (s < WIN) begin
         bit en;
         logic [NUMINPUTS-1:0] re_v;
         logic [NUMINPUTS-1:0] im_v;
         en = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? bit'(c % 2) : ($urandom_range(0, 2) != 0);
         if (en) begin
            for (int k = 0; k < NUMINPUTS; k++) begin
               re_v[k] = gen_bit(pat, 0, k, s);
               im_v[k] = gen_bit(pat, 1, k, s);
               cnt_re[k] += int'(re_v[k]);
               cnt_im[k] += int'(im_v[k]);
            end
            s++;
         end else begin
            re_v = NUMINPUTS'($urandom);
            im_v = NUMINPUTS'($urandom);
         end
         if (bus.oValid) early_valid++;
         bus.iEn    = en;
         bus.iReal  = re_v;
         bus.iImg   = im_v;
         bus.iStart = start_noise && ($urandom_range(0, 7) == 0);
         c++;
         @(negedge clk);
      end
      bus.iStart = 1'b0;
      check_val("no_early_valid", 64'(early_valid), 64'(0));
      check_val("valid_latency", 64'(bus.oValid), 64'(1));
      if (en_mode == 1) check_val("clocks_512", 64'(c), 64'(2 * WIN));
      for (int k = 0; k < NUMINPUTS; k++)
         exp_q.push_back({IDXW'(k), decode_ref(cnt_re[k]), decode_ref(cnt_im[k])});
   endtask

   task automatic drain(input bit rand_ready, input int stall_beat, input int stall_len,
                        input int abort_beat);
      int beat = 0;
      int stall = 0;
      int guard = 0;
      int stray_done = 0;
      while (exp_q.size() > 0) begin
         bit rdy;
         if (guard++ > 500) begin
            check_val("drain_timeout", 64'(1), 64'(0));
            exp_q.delete();
            break;
         end
         check_val($sformatf("beat%0d", beat), 64'({bus.oValid, bus.oIdx, bus.oRealVal, bus.oImgVal}),
                   64'({1'b1, exp_q[0]}));
         if (beat == abort_beat) begin
            rst_n = 1'b0;
            exp_q.delete();
            @(negedge clk);
            check_val("reset_outputs", out_word(), 64'(0));
            rst_n = 1'b1;
            bus.iStart = 1'b0;
            bus.iReady = 1'b0;
            repeat (3) begin
               @(negedge clk);
               if (bus.oDone || bus.oBusy) stray_done++;
            end
            check_val("reset_no_done", 64'(stray_done), 64'(0));
            return;
         end
         if (beat == stall_beat && stall < stall_len) begin
            rdy = 1'b0;
            stall++;
         end else begin
            rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
         bus.iReady = rdy;
         bus.iStart = 1'($urandom);
         bus.iEn    = 1'($urandom);
         bus.iReal  = NUMINPUTS'($urandom);
         bus.iImg   = NUMINPUTS'($urandom);
         @(negedge clk);
         if (rdy) begin
            void'(exp_q.pop_front());
            beat++;
         end
      end
      bus.iReady = 1'b0;
      bus.iStart = 1'b0;
      if (stall_len > 0) check_val("stall_cycles", 64'(stall), 64'(stall_len));
      check_val("done_pulse", 64'({bus.oDone, bus.oValid, bus.oBusy}), 64'(3'b100));
      @(negedge clk);
      check_val("done_once", 64'(bus.oDone), 64'(0));
   endtask

   task automatic clr_abort();
      int s = 0;
      @(negedge clk);
      bus.iStart = 1'b1;
      @(negedge clk);
      bus.iStart = 1'b0;
      while (s < 100) begin
         bus.iEn   = 1'b1;
         bus.iReal = '1;
         bus.iImg  = '1;
         s++;
         if (s == 100) bus.iClr = 1'b1;
         @(negedge clk);
      end
      bus.iClr = 1'b0;
      bus.iEn  = 1'b0;
      check_val("clr_idle", out_word(), 64'(0));
      @(negedge clk);
      check_val("clr_no_done", 64'({bus.oDone, bus.oBusy}), 64'(0));
   endtask

   initial begin
      bus.iEn    = 1'b0;
      bus.iClr   = 1'b0;
      bus.iStart = 1'b0;
      bus.iReal  = '0;
      bus.iImg   = '0;
      bus.iReady = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_state", out_word(), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check_val("idle_state", out_word(), 64'(0));

      run_accum(0, 0, 1'b0);
      check_val("all_ones_lane0", 64'({bus.oRealVal, bus.oImgVal}), 64'({10'sd256, -10'sd256}));
      drain(1'b0, -1, 0, -1);

      run_accum(1, 0, 1'b0);
      drain(1'b0, -1, 0, -1);

      run_accum(0, 1, 1'b1);
      drain(1'b0, -1, 0, -1);

      run_accum(2, 0, 1'b0);
      drain(1'b0, 2, 5, -1);

      for (int i = 0; i < 4; i++) begin
         run_accum(2, 2, 1'b1);
         drain(1'b1, -1, 0, -1);
      end

      @(negedge clk);
      bus.iStart = 1'b1;
      bus.iClr   = 1'b1;
      @(negedge clk);
      bus.iStart = 1'b0;
      bus.iClr   = 1'b0;
      check_val("clr_over_start", 64'(bus.oBusy), 64'(0));

      clr_abort();
      run_accum(3, 0, 1'b0);
      drain(1'b0, -1, 0, -1);

      run_accum(2, 0, 1'b0);
      drain(1'b0, -1, 0, 4);
      run_accum(0, 0, 1'b0);
      drain(1'b1, -1, 0, -1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
